snn_layer_sequencer: RTL and testbench
======================================

// Module: snn_layer_sequencer
// PURPOSE
//  FSM/counter controller that sequences the snn_core MAC datapath through inference.
//  Hidden layer: N_IN 1-bit pixels x N_HID neurons. Output layer: N_HID hidden acts x N_OUT neurons.
//  Drives the RAM/ROM addresses, MAC clear/enable, the layer mux select and the hidden-RAM write.
//  Tracks the argmax of the output activations and reports the recognised digit.
// PARAMETERS
//  N_IN   784  input units (pixels); addr_input_unit width 10
//  N_HID  32   hidden neurons; addr_hidden_unit width 5
//  N_OUT  10   output neurons; digit width 4
// PORTS
//  clk                 in   1   system clock, all state on rising edge
//  rst_n               in   1   asynchronous active-low reset
//  start               in   1   begin inference; sampled only in IDLE
//  act_q               in   8   activation-LUT output, unsigned, valid 1 cycle after ACT state
//  addr_input_unit     out  10  input-RAM read address
//  addr_hidden_weight  out  15  hidden weight-ROM address (h*N_IN + i)
//  addr_hidden_unit    out  5   hidden-RAM addr: write addr in WR_HID, read addr in output layer
//  addr_output_weight  out  9   output weight-ROM address (o*N_HID + j)
//  mac_clr             out  1   clear accumulator (priority over mac_en in the datapath)
//  mac_en              out  1   accumulate product of current RAM/ROM read data
//  sel_layer           out  1   0 = hidden-layer operands, 1 = output-layer operands
//  we_hidden           out  1   write act_q into hidden RAM at addr_hidden_unit
//  digit               out  4   argmax index of output activations; held until the next done
//  done                out  1   one-cycle pulse when digit is valid
// BEHAVIOUR
//  Reset: state IDLE; all counters, addresses, strobes, digit, done = 0; running max = 0.
//  RAM/ROM and activation LUT are synchronous, 1-cycle read latency.
//  mac_en is the address-valid flag delayed 1 cycle.
//  States: IDLE, MAC_H, DRN_H, ACT_H, WR_H, MAC_O, DRN_O, ACT_O, CMP_O, DONE.
//  IDLE: start=1 -> MAC_H, with h=0, i=0, weight addr=0. start in any other state is ignored.
//  MAC_H: N_IN cycles. Issues addr_input_unit=i and addr_hidden_weight; i and weight addr +1 per cycle.
//   mac_clr=1 in the cycle i==0. After i==N_IN-1 -> DRN_H.
//   Weight address is a free-running counter, not a multiply; it is continuous across neurons.
//  DRN_H: 1 cycle, no address valid; the final mac_en occurs here -> ACT_H.
//  ACT_H: 1 cycle; LUT reads the MAC result -> WR_H.
//  WR_H: we_hidden=1, addr_hidden_unit=h.
//   If h==N_HID-1 -> MAC_O with o=0, j=0. Else h+1, i=0 -> MAC_H.
//  MAC_O/DRN_O/ACT_O: same as hidden layer with sel_layer=1.
//   Runs over j=0..N_HID-1; addr_hidden_unit=j, addr_output_weight=o*N_HID+j (running counter).
//  CMP_O: 1 cycle. If o==0 or act_q > max (strict, unsigned): max<=act_q, idx<=o.
//   Ties keep the lower index. If o==N_OUT-1 -> DONE. Else o+1 -> MAC_O.
//  DONE: done=1 for 1 cycle, digit<=idx (registered, visible same cycle as done) -> IDLE.
//  Per-neuron cost: hidden N_IN+3 = 787 cycles; output N_HID+3 = 35 cycles.
//  Latency: done is high 25535 clock edges after the edge that samples start (defaults).
//  Outside MAC_x/DRN_x: mac_en=0. Outside WR_H: we_hidden=0. Addresses never exceed range.
//  Wrap: weight-address counters reset to 0 on each start, never rolled by the controller.
//  rst_n low mid-inference: immediate async return to IDLE, outputs per reset.
//   No done pulse; the hidden RAM contents are don't-care.
//  start held high through DONE: a new inference begins on the cycle after DONE (IDLE samples it).
// TESTING
//  1 Reset: assert rst_n=0 mid-MAC_H -> all outputs 0 same cycle; state IDLE; no done afterwards.
//  2 Timing: start pulse -> done exactly 25535 edges later, single cycle.
//    mac_clr seen exactly 42 times (32 hidden + 10 output).
//  3 Addresses: addr_hidden_weight sweeps 0..25087 monotonically, 784 mac_en per hidden neuron.
//    addr_output_weight sweeps 0..319.
//  4 Writes: we_hidden pulses 32 times with addr_hidden_unit 0..31 in order, each after ACT_H.
//  5 Argmax: act_q model gives output acts {3,9,9,1,...} -> digit=1 (tie to lower).
//    All-zero acts -> digit=0.
//  6 start during busy ignored; start held high -> back-to-back inferences.
//    Second done 25536 edges after the first.

Source files
------------

// File: rtl/snn_layer_sequencer.sv
// Inference sequencer for the snn_core MAC datapath: steps the hidden and output
// layers through MAC/drain/activate phases and reports the argmax output neuron.
module snn_layer_sequencer #(
  parameter  int unsigned N_IN  = 784,
  parameter  int unsigned N_HID = 32,
  parameter  int unsigned N_OUT = 10,
  localparam int unsigned IW    = $clog2(N_IN),
  localparam int unsigned HW    = $clog2(N_HID),
  localparam int unsigned OW    = $clog2(N_OUT),
  localparam int unsigned HWW   = $clog2(N_IN * N_HID),
  localparam int unsigned OWW   = $clog2(N_HID * N_OUT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [7:0]     act_q,
  output logic [IW-1:0]  addr_input_unit,
  output logic [HWW-1:0] addr_hidden_weight,
  output logic [HW-1:0]  addr_hidden_unit,
  output logic [OWW-1:0] addr_output_weight,
  output logic           mac_clr,
  output logic           mac_en,
  output logic           sel_layer,
  output logic           we_hidden,
  output logic [OW-1:0]  digit,
  output logic           done
);

  localparam logic [IW-1:0]  I_LAST  = IW'(N_IN - 1);
  localparam logic [HW-1:0]  H_LAST  = HW'(N_HID - 1);
  localparam logic [HW-1:0]  J_LAST  = HW'(N_HID - 1);
  localparam logic [OW-1:0]  O_LAST  = OW'(N_OUT - 1);
  localparam logic [HWW-1:0] WH_LAST = HWW'(N_IN * N_HID - 1);
  localparam logic [OWW-1:0] WO_LAST = OWW'(N_HID * N_OUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MAC_H,
    S_DRN_H,
    S_ACT_H,
    S_WR_H,
    S_MAC_O,
    S_DRN_O,
    S_ACT_O,
    S_CMP_O,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic [HW-1:0]  h_q, h_d;
  logic [HW-1:0]  j_q, j_d;
  logic [OW-1:0]  o_q, o_d;
  logic [HWW-1:0] wh_q, wh_d;
  logic [OWW-1:0] wo_q, wo_d;
  logic [HW-1:0]  hu_q, hu_d;
  logic           clr_q, clr_d;
  logic           en_q, en_d;
  logic           sel_q, sel_d;
  logic           we_q, we_d;
  logic           done_q, done_d;
  logic [OW-1:0]  digit_q, digit_d;
  logic [7:0]     max_q, max_d;
  logic [OW-1:0]  idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      h_q     <= '0;
      j_q     <= '0;
      o_q     <= '0;
      wh_q    <= '0;
      wo_q    <= '0;
      hu_q    <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      digit_q <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      h_q     <= h_d;
      j_q     <= j_d;
      o_q     <= o_d;
      wh_q    <= wh_d;
      wo_q    <= wo_d;
      hu_q    <= hu_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      done_q  <= done_d;
      digit_q <= digit_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    h_d     = h_q;
    j_d     = j_q;
    o_d     = o_q;
    wh_d    = wh_q;
    wo_d    = wo_q;
    hu_d    = hu_q;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    sel_d   = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    digit_d = digit_q;
    max_d   = max_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC_H;
          i_d     = '0;
          h_d     = '0;
          j_d     = '0;
          o_d     = '0;
          wh_d    = '0;
          wo_d    = '0;
        end
      end
      S_MAC_H: begin
        // weight address runs continuously across neurons; it parks on its last value
        if (wh_q != WH_LAST) wh_d = wh_q + HWW'(1);
        if (i_q == I_LAST) begin
          i_d     = '0;
          state_d = S_DRN_H;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_DRN_H: state_d = S_ACT_H;
      S_ACT_H: state_d = S_WR_H;
      S_WR_H: begin
        if (h_q == H_LAST) begin
          state_d = S_MAC_O;
          o_d     = '0;
          j_d     = '0;
          wo_d    = '0;
        end else begin
          h_d     = h_q + HW'(1);
          i_d     = '0;
          state_d = S_MAC_H;
        end
      end
      S_MAC_O: begin
        if (wo_q != WO_LAST) wo_d = wo_q + OWW'(1);
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = S_DRN_O;
        end else begin
          j_d = j_q + HW'(1);
        end
      end
      S_DRN_O: state_d = S_ACT_O;
      S_ACT_O: state_d = S_CMP_O;
      S_CMP_O: begin
        // strict compare keeps the lower index on ties
        if ((o_q == '0) || (act_q > max_q)) begin
          max_d = act_q;
          idx_d = o_q;
        end
        if (o_q == O_LAST) begin
          state_d = S_DONE;
        end else begin
          o_d     = o_q + OW'(1);
          j_d     = '0;
          state_d = S_MAC_O;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // strobes are registered, so they are derived from the state being entered
    clr_d  = ((state_d == S_MAC_H) && (i_d == '0)) ||
             ((state_d == S_MAC_O) && (j_d == '0));
    en_d   = (state_q == S_MAC_H) || (state_q == S_MAC_O);
    sel_d  = (state_d == S_MAC_O) || (state_d == S_DRN_O) ||
             (state_d == S_ACT_O) || (state_d == S_CMP_O);
    we_d   = (state_d == S_WR_H);
    done_d = (state_q == S_DONE);
    if (state_d == S_WR_H) begin
      hu_d = h_d;
    end else if (state_d == S_MAC_O) begin
      hu_d = j_d;
    end
    if (state_q == S_DONE) digit_d = idx_q;
  end

  assign addr_input_unit    = i_q;
  assign addr_hidden_weight = wh_q;
  assign addr_hidden_unit   = hu_q;
  assign addr_output_weight = wo_q;
  assign mac_clr            = clr_q;
  assign mac_en             = en_q;
  assign sel_layer          = sel_q;
  assign we_hidden          = we_q;
  assign digit              = digit_q;
  assign done               = done_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Directed bench for snn_layer_sequencer: reset, latency, address sweeps,
// hidden writes, argmax with ties, busy-start and back-to-back inferences.
module tb_snn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  act_q;
  logic [9:0]  addr_input_unit;
  logic [14:0] addr_hidden_weight;
  logic [4:0]  addr_hidden_unit;
  logic [8:0]  addr_output_weight;
  logic        mac_clr;
  logic        mac_en;
  logic        sel_layer;
  logic        we_hidden;
  logic [3:0]  digit;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  acts [10];
  logic [3:0]  out_cnt;
  logic        mon_clr;
  logic [47:0] outs;

  int clr_cnt, en_h_cnt, en_o_cnt, en_seg, seg_err;
  int we_cnt, we_err, done_cnt, max_wh, max_wo, mono_err, prev_wh, prev_wo;
  int n;
  bit got;

  always #5 clk = ~clk;

  snn_layer_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .act_q              (act_q),
    .addr_input_unit    (addr_input_unit),
    .addr_hidden_weight (addr_hidden_weight),
    .addr_hidden_unit   (addr_hidden_unit),
    .addr_output_weight (addr_output_weight),
    .mac_clr            (mac_clr),
    .mac_en             (mac_en),
    .sel_layer          (sel_layer),
    .we_hidden          (we_hidden),
    .digit              (digit),
    .done               (done)
  );

  assign outs = {addr_input_unit, addr_hidden_weight, addr_hidden_unit, addr_output_weight,
                 mac_clr, mac_en, sel_layer, we_hidden, digit, done};

  // LUT model: output neuron o presents acts[o] from its first MAC_O cycle through CMP_O
  assign act_q = (out_cnt == 4'd0) ? 8'd0 : acts[out_cnt - 4'd1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_cnt <= 4'd0;
    else if (done) out_cnt <= 4'd0;
    else if (mac_clr && sel_layer && out_cnt != 4'd10) out_cnt <= out_cnt + 4'd1;
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      clr_cnt = 0; en_h_cnt = 0; en_o_cnt = 0; en_seg = 0; seg_err = 0;
      we_cnt = 0; we_err = 0; done_cnt = 0; max_wh = 0; max_wo = 0;
      mono_err = 0; prev_wh = 0; prev_wo = 0;
    end else begin
      if (mac_clr) clr_cnt++;
      if (mac_en && !sel_layer) begin en_h_cnt++; en_seg++; end
      if (mac_en && sel_layer) en_o_cnt++;
      if (we_hidden) begin
        if (en_seg != 784) seg_err++;
        if (int'(addr_hidden_unit) != we_cnt) we_err++;
        we_cnt++;
        en_seg = 0;
      end
      if (int'(addr_hidden_weight) < prev_wh) mono_err++;
      if (int'(addr_output_weight) < prev_wo) mono_err++;
      prev_wh = int'(addr_hidden_weight);
      prev_wo = int'(addr_output_weight);
      if (prev_wh > max_wh) max_wh = prev_wh;
      if (prev_wo > max_wo) max_wo = prev_wo;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    mon_clr = 1'b1;
    for (int k = 0; k < 10; k++) acts[k] = 8'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 64'(outs), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    mon_clr = 1'b0;

    // abort mid hidden-MAC with an asynchronous reset
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_clr", 64'(mac_clr), 64'd1);
    repeat (300) @(posedge clk);
    #1;
    check("mid_addr_in", 64'(addr_input_unit), 64'd300);
    check("mid_addr_hw", 64'(addr_hidden_weight), 64'd300);
    check("mid_mac_en", 64'(mac_en), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 64'(outs), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("post_rst_done_cnt", 64'(done_cnt), 64'd0);
    check("post_rst_clr_cnt", 64'(clr_cnt), 64'd0);
    check("post_rst_idle_outs", 64'(outs), 64'd0);

    // run A: tie between neurons 1 and 2 resolves to 1; start pulse while busy ignored
    acts[0] = 8'd3; acts[1] = 8'd9; acts[2] = 8'd9; acts[3] = 8'd1; acts[4] = 8'd0;
    acts[5] = 8'd2; acts[6] = 8'd5; acts[7] = 8'd0; acts[8] = 8'd8; acts[9] = 8'd7;
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("runA_clr0", 64'(mac_clr), 64'd1);
    check("runA_sel0", 64'(sel_layer), 64'd0);
    n   = 0;
    got = 1'b0;
    while (n < 30000 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1000) start = 1'b1;
      if (n == 1003) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("runA_latency", 64'(n), 64'd25535);
    check("runA_digit", 64'(digit), 64'd1);
    @(posedge clk);
    #1;
    check("runA_done_single", 64'(done), 64'd0);
    check("runA_done_cnt", 64'(done_cnt), 64'd1);
    check("runA_clr_cnt", 64'(clr_cnt), 64'd42);
    check("runA_en_hidden", 64'(en_h_cnt), 64'd25088);
    check("runA_en_output", 64'(en_o_cnt), 64'd320);
    check("runA_en_per_neuron", 64'(seg_err), 64'd0);
    check("runA_we_cnt", 64'(we_cnt), 64'd32);
    check("runA_we_order", 64'(we_err), 64'd0);
    check("runA_max_wh", 64'(max_wh), 64'd25087);
    check("runA_max_wo", 64'(max_wo), 64'd319);
    check("runA_monotonic", 64'(mono_err), 64'd0);

    // run B: all-zero acts, start held high -> back-to-back inference
    repeat (5) @(posedge clk);
    #1;
    check("idle_digit_held", 64'(digit), 64'd1);
    for (int k = 0; k < 10; k++) acts[k] = 8'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    n   = 0;
    got = 1'b0;
    while (n < 30000 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20000) check("runB_digit_held", 64'(digit), 64'd1);
      if (done) got = 1'b1;
    end
    check("runB_latency", 64'(n), 64'd25535);
    check("runB_digit_zero", 64'(digit), 64'd0);
    acts[9] = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 1;
    got   = 1'b0;
    check("runC_done_single", 64'(done), 64'd0);
    check("runC_restart_clr", 64'(mac_clr), 64'd1);
    while (n < 30000 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    check("runC_back_to_back", 64'(n), 64'd25536);
    check("runC_digit", 64'(digit), 64'd9);
    repeat (3) @(posedge clk);
    #1;
    check("final_idle_en", 64'(mac_en), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
